instr_fetch_issue: RTL and testbench

//  Producer side of the decode interface: fetches 32-bit instruction words from

---
 rtl/core_pkg.sv | 28 ++
 rtl/insn_field_split.sv | 22 ++
 rtl/instr_fetch_issue.sv | 136 +++++++++++++
 tb/tb_instr_fetch_issue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, HALT encoding, field bit positions
// and the fetch-side state encoding.
package core_pkg;

    localparam int INSN_W = 32;
    localparam logic [INSN_W-1:0] HALT_WORD = 32'h0000_0000;

    localparam int MSB_BIT = 31;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/insn_field_split.sv
// Purely combinational split of an instruction word into the fields the control
// unit and register file consume.
module insn_field_split
    import core_pkg::*;
(
    input  logic [INSN_W-1:0] ir,
    output logic              insmsb,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm
);

    assign insmsb = ir[MSB_BIT];
    assign func   = ir[FUNC_HI:FUNC_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign imm    = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: owns the PC, reads imem one word at a time and offers the
// decoded fields to the control unit over a valid/ready handshake.
module instr_fetch_issue
    import core_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic              insmsb,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] iss_pc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted,
    output fetch_state_e      fsm_state
);

    // Handshake: a word transfers on any rising edge where iss_valid && iss_ready.
    // Once raised, iss_valid and all fields stay stable until that transfer or a
    // redirect; iss_valid never depends combinationally on iss_ready.

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] ir;
    logic              drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_REQ;
            S_REQ:   state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    // A stale or redirected response is discarded, even a HALT word.
                    if (drop || br_valid)            state_next = S_REQ;
                    else if (imem_rdata == HALT_WORD) state_next = S_HALT;
                    else                             state_next = S_ISSUE;
                end
            end
            S_ISSUE: if (br_valid || iss_ready) state_next = S_REQ;
            S_HALT:  if (start) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        iss_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            S_REQ:   imem_req  = 1'b1;
            S_ISSUE: iss_valid = 1'b1;
            S_HALT:  halted    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ir     <= '0;
            iss_pc <= '0;
            drop   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc   <= RESET_PC;
                        drop <= 1'b0;
                    end
                end
                S_REQ: begin
                    // The request leaving this cycle is already addressed to the old pc.
                    if (br_valid) begin
                        pc   <= br_target;
                        drop <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (br_valid) begin
                        pc   <= br_target;
                        drop <= ~imem_rvalid;
                    end else if (imem_rvalid) begin
                        if (drop) begin
                            drop <= 1'b0;
                        end else if (imem_rdata != HALT_WORD) begin
                            ir     <= imem_rdata;
                            iss_pc <= pc;
                        end
                    end
                end
                S_ISSUE: begin
                    if (br_valid)       pc <= br_target;
                    else if (iss_ready) pc <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign fsm_state = state;

    insn_field_split u_split (
        .ir     (ir),
        .insmsb (insmsb),
        .func   (func),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .imm    (imm)
    );

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: latency-programmable imem model, scoreboard of issued
// words, a table of field-decode vectors and hand-written redirect/halt/reset sequences.
module tb_instr_fetch_issue;
    import core_pkg::*;

    localparam int AW = 8;
    localparam int W  = AW + 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          iss_valid;
    logic          iss_ready;
    logic          insmsb;
    logic [5:0]    func;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [AW-1:0] iss_pc;
    logic          br_valid;
    logic [AW-1:0] br_target;
    logic          halted;
    fetch_state_e  fsm_state;

    instr_fetch_issue #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .insmsb(insmsb), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .iss_pc(iss_pc), .br_valid(br_valid), .br_target(br_target),
        .halted(halted), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    logic [31:0] mem     [256];
    int          lat_mem [256];
    logic        mem_en = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = '0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = '0;
    assign imem_rvalid = mem_en ? mem_rvalid : man_rvalid;
    assign imem_rdata  = mem_en ? mem_rdata  : man_rdata;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;
    pend_t pend_q[$];
    pend_t pend;
    int    cyc = 0;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          rdy_dly;
        logic [37:0] fexp;  // {insmsb, func, rs, rt, rd, imm}
    } vec_t;
    vec_t vecs[5];

    function automatic logic [37:0] fields_of(input logic [31:0] w);
        return {w[31], w[5:0], w[25:21], w[20:16], w[15:11], w[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!iss_valid && k < 40) begin
            tick();
            k++;
        end
        check(name, {63'd0, iss_valid}, 64'd1);
    endtask

    task automatic handshake_one(input logic [AW-1:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
        wait_valid("issue_wait");
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
    endtask

    // imem model: one in-order response per request after lat_mem[addr] cycles.
    always @(negedge clk) begin
        cyc++;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            pend_q.delete();
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                pend = pend_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = mem[pend.addr];
            end
            if (imem_req) pend_q.push_back('{imem_addr, cyc + lat_mem[imem_addr]});
        end
    end

    // Scoreboard: each transfer is compared with the oldest expected {pc, word}.
    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {56'd0, iss_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_issue", {18'd0, iss_pc, insmsb, func, rs, rt, rd, imm},
                      {18'd0, e[W-1:32], fields_of(e[31:0])});
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {7'd0, imem_req, imem_addr, iss_valid, halted, insmsb, func, rs, rt, rd,
                     imm, iss_pc}, 64'd0);
        check({name, "_state"}, {61'd0, fsm_state}, {61'd0, S_IDLE});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{32'h8C22_0004, 1, 0, {1'b1, 6'h04, 5'd1,  5'd2,  5'd0,  16'h0004}};
        vecs[1] = '{32'h0043_0820, 3, 2, {1'b0, 6'h20, 5'd2,  5'd3,  5'd1,  16'h0820}};
        vecs[2] = '{32'hFFFF_FFFF, 2, 0, {1'b1, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF}};
        vecs[3] = '{32'h03E0_F83F, 4, 3, {1'b0, 6'h3F, 5'h1F, 5'h00, 5'h1F, 16'hF83F}};
        vecs[4] = '{32'h8000_0001, 1, 1, {1'b1, 6'h01, 5'd0,  5'd0,  5'd0,  16'h0001}};

        for (int a = 0; a < 256; a++) begin
            mem[a]     = 32'h1000_0000 | 32'(a) | (32'($urandom_range(1, 255)) << 16);
            lat_mem[a] = 1;
        end
        mem[0]    = 32'h0000_0025;
        mem[1]    = 32'h8001_0010;
        mem[2]    = 32'h0A0B_0C0D;
        mem[3]    = 32'h0000_0000;
        lat_mem[2] = 2;
        mem[8'h45] = 32'h1234_5678;
        mem[8'hFF] = 32'hABCD_EF01;
        for (int i = 0; i < 5; i++) begin
            mem[8'h40 + i]     = vecs[i].word;
            lat_mem[8'h40 + i] = vecs[i].lat;
        end

        rst_n = 1'b0; start = 1'b0; iss_ready = 1'b0; br_valid = 1'b0; br_target = '0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // start -> req@0 -> wait -> issue (imem latency 1)
        exp_q.push_back({8'h00, mem[0]});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_req", {55'd0, imem_req, iss_valid, imem_addr}, {55'd0, 1'b1, 1'b0, 8'h00});
        tick();
        check("t1_wait", {62'd0, imem_req, iss_valid}, 64'd0);
        tick();
        check("t1_issue", {16'd0, iss_valid, insmsb, func, iss_pc}, {16'd0, 1'b1, 1'b0, 6'h25, 8'h00});
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t1_next_req", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'h01});

        // Back-pressure: fields stable and no fetch while ready is low
        exp_q.push_back({8'h01, mem[1]});
        wait_valid("t2_wait");
        for (int k = 0; k < 5; k++) begin
            check("t2_stall", {16'd0, iss_valid, imem_req, insmsb, func, rs, rt, rd, imm, iss_pc},
                  {16'd0, 1'b1, 1'b0, 1'b1, 6'h10, 5'd0, 5'd1, 5'd0, 16'h0010, 8'h01});
            tick();
        end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t2_next_req", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'h02});

        // Redirect while waiting; the in-flight word for addr 2 must be discarded
        tick();
        br_valid = 1'b1; br_target = 8'h40;
        tick();
        br_valid = 1'b0;
        check("t3_wait", {59'd0, imem_req, iss_valid, fsm_state}, {59'd0, 1'b0, 1'b0, S_WAIT});
        tick();
        check("t3_redirect_req", {54'd0, imem_req, iss_valid, imem_addr},
              {54'd0, 1'b1, 1'b0, 8'h40});
        tick();
        check("t3_no_issue", {62'd0, iss_valid, halted}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({8'(8'h40 + i), vecs[i].word});
            wait_valid("vec_wait");
            check("vec_fields", {26'd0, insmsb, func, rs, rt, rd, imm}, {26'd0, vecs[i].fexp});
            for (int k = 0; k < vecs[i].rdy_dly; k++) begin
                tick();
                check("vec_hold", {62'd0, iss_valid, imem_req}, {62'd0, 1'b1, 1'b0});
            end
            iss_ready = 1'b1;
            tick();
            iss_ready = 1'b0;
            check("vec_next_req", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'(8'h41 + i)});
        end

        // Redirect coinciding with a handshake: word accepted, pc takes the target
        exp_q.push_back({8'h45, mem[8'h45]});
        wait_valid("br_issue_wait");
        iss_ready = 1'b1; br_valid = 1'b1; br_target = 8'hFF;
        tick();
        iss_ready = 1'b0; br_valid = 1'b0;
        check("br_issue_req", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'hFF});

        // PC wrap
        handshake_one(8'hFF, mem[8'hFF]);
        check("t4_wrap", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'h00});
        handshake_one(8'h00, mem[0]);
        handshake_one(8'h01, mem[1]);
        handshake_one(8'h02, mem[2]);

        // HALT word at addr 3
        for (int k = 0; k < 20 && !halted; k++) tick();
        check("t5_halted", {60'd0, halted, fsm_state}, {60'd0, 1'b1, S_HALT});
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_quiet", {62'd0, imem_req, iss_valid}, 64'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_restart", {54'd0, halted, imem_req, imem_addr}, {54'd0, 1'b0, 1'b1, 8'h00});

        // Reset while ISSUE, then a late response that must be ignored
        exp_q.push_back({8'h00, mem[0]});
        wait_valid("t6_wait");
        rst_n = 1'b0;
        mem_en = 1'b0;
        #1;
        check_all_zero("t6_async");
        void'(exp_q.pop_front());
        tick(); tick();
        rst_n = 1'b1;
        tick();
        man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        man_rvalid = 1'b0;
        check_all_zero("t6_late_rvalid");
        tick();
        check_all_zero("t6_idle");
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
